// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//   Port 0 is the core datapath, port 1 the helper/accelerator path.
//   Requests arrive on valid/ready channels and are granted round-robin; the
//   granted operands/opcode/immediate are registered onto the alu_* outputs,
//   the ALU result is captured one cycle later and returned to the owning
//   requester on its valid/ready response channel.
// Ports:
//   Clk, Reset                     clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op/im     request channel for requester N (0/1)
//   respN_valid/ready/data/branch  response channel for requester N (0/1)
//   alu_a/alu_b/alu_op/alu_im      registered drive to the external ALU
//   alu_out/alu_branch             external ALU results
//   busy                           operation in flight (state != IDLE)
//   grant_cnt0/grant_cnt1          saturating accepted-request counters
module alu_arbiter #(
  parameter int W       = 8,
  parameter int OPW     = 4,
  parameter int IMW     = 3,
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [IMW-1:0]   req0_im,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic [IMW-1:0]   req1_im,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [W-1:0]     resp0_data,
  output logic             resp0_branch,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [W-1:0]     resp1_data,
  output logic             resp1_branch,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic [IMW-1:0]   alu_im,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_branch,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [IMW-1:0]   alu_im_q, alu_im_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_branch_q, res_branch_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             gnt0_s, gnt1_s;
  logic             resp_accept_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt0_s = req0_valid & (~req1_valid | ~ptr_q);
    gnt1_s = req1_valid & (~req0_valid |  ptr_q);
  end

  // Request ready is only offered while idle, and only to the granted port.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == S_IDLE) begin
      req0_ready = gnt0_s;
      req1_ready = gnt1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Response handshake of whichever port owns the current result.
  always_comb begin
    resp_accept_s = 1'b0;
    if (owner_q) begin
      resp_accept_s = resp1_valid_q & resp1_ready;
    end else begin
      resp_accept_s = resp0_valid_q & resp0_ready;
    end
  end

  // Next-state and datapath-register update logic of the IDLE/EXEC/RESP FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_im_d      = alu_im_q;
    res_data_d    = res_data_q;
    res_branch_d  = res_branch_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;

    case (state_q)
      S_IDLE: begin
        if (gnt1_s) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          alu_im_d = req1_im;
          owner_d  = 1'b1;
          cnt1_d   = sat_inc(cnt1_q);
          state_d  = S_EXEC;
        end else if (gnt0_s) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          alu_im_d = req0_im;
          owner_d  = 1'b0;
          cnt0_d   = sat_inc(cnt0_q);
          state_d  = S_EXEC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable for the whole cycle; sample its result.
        res_data_d    = alu_out;
        res_branch_d  = alu_branch;
        resp0_valid_d = ~owner_q;
        resp1_valid_d =  owner_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (resp_accept_s) begin
          // Priority passes to the other port only once an operation completes.
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          ptr_d         = ~owner_q;
          state_d       = S_IDLE;
        end else begin
          state_d       = S_RESP;
        end
      end
      default: begin
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= 1'(RR_INIT);
      owner_q       <= 1'b0;
      alu_a_q       <= {W{1'b0}};
      alu_b_q       <= {W{1'b0}};
      alu_op_q      <= {OPW{1'b0}};
      alu_im_q      <= {IMW{1'b0}};
      res_data_q    <= {W{1'b0}};
      res_branch_q  <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      cnt0_q        <= {CNT_W{1'b0}};
      cnt1_q        <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_im_q      <= alu_im_d;
      res_data_q    <= res_data_d;
      res_branch_q  <= res_branch_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      busy_q        <= busy_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_im       = alu_im_q;
  assign resp0_valid  = resp0_valid_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp0_data   = res_data_q;
  assign resp1_data   = res_data_q;
  assign resp0_branch = res_branch_q;
  assign resp1_branch = res_branch_q;
  assign busy         = busy_q;
  assign grant_cnt0   = cnt0_q;
  assign grant_cnt1   = cnt1_q;

endmodule
